// File: rtl/input_port_vc.sv
// Router input port: one circular flit buffer per virtual channel plus a per-VC
// RC -> VA -> SA control FSM feeding a single registered crossbar output.
package input_port_vc_pkg;
  localparam int VC_ID_W = 4;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_ID_W-1:0] vc_id;
    logic [DATA_W-1:0]  data;
  } flit_t;
endpackage

module input_port_vc
  import input_port_vc_pkg::*;
#(
  parameter int  VC_NUM      = 2,
  parameter int  BUFFER_SIZE = 8,
  parameter int  PORT_NUM    = 5,
  localparam int PORT_W      = $clog2(PORT_NUM),
  localparam int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  flit_t                         data_i,
  input  logic                          valid_flit_i,
  output logic [VC_NUM-1:0]             is_full_o,
  output logic [VC_NUM-1:0]             is_empty_o,
  output flit_t [VC_NUM-1:0]            rc_head_o,
  input  logic [VC_NUM-1:0][PORT_W-1:0] rc_port_i,
  output logic [VC_NUM-1:0]             va_req_o,
  output logic [VC_NUM-1:0][PORT_W-1:0] va_port_o,
  input  logic [VC_NUM-1:0]             va_grant_i,
  input  logic [VC_NUM-1:0][VC_W-1:0]   va_vc_i,
  output logic [VC_NUM-1:0]             sa_req_o,
  output logic [VC_NUM-1:0][PORT_W-1:0] sa_port_o,
  input  logic [VC_NUM-1:0]             sa_grant_i,
  output flit_t                         xb_flit_o,
  output logic                          xb_valid_o,
  output logic [PORT_W-1:0]             xb_port_o,
  output logic                          error_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RC     = 2'd1,
    S_VA     = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  function automatic logic is_head(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_last(input flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction

  flit_t             mem_r      [VC_NUM][BUFFER_SIZE];
  logic [PTR_W-1:0]  wr_ptr_r   [VC_NUM];
  logic [PTR_W-1:0]  rd_ptr_r   [VC_NUM];
  logic [CNT_W-1:0]  cnt_r      [VC_NUM];
  logic [CNT_W-1:0]  cnt_nxt_s  [VC_NUM];
  state_t            state_r    [VC_NUM];
  logic [PORT_W-1:0] out_port_r [VC_NUM];
  logic [VC_W-1:0]   down_vc_r  [VC_NUM];
  flit_t             front_s    [VC_NUM];

  logic [VC_NUM-1:0] is_full_r, is_empty_r;
  logic [VC_NUM-1:0] push_s, pop_s, sa_pop_s;
  logic [VC_W-1:0]   wr_vc_s, sa_sel_s;
  logic              sa_multi_s, err_s, vc_empty_s, idle_drop_s, wr_hit_s;
  flit_t             pop_flit_s;
  logic [PORT_W-1:0] pop_port_s;

  flit_t             xb_flit_r;
  logic              xb_valid_r, error_r;
  logic [PORT_W-1:0] xb_port_r;

  // Push/pop decisions, grant arbitration, violation detection and request outputs
  always_comb begin
    wr_vc_s     = data_i.vc_id[VC_W-1:0];
    sa_sel_s    = '0;
    vc_empty_s  = 1'b0;
    idle_drop_s = 1'b0;
    wr_hit_s    = 1'b0;
    push_s      = '0;
    pop_s       = '0;
    sa_pop_s    = '0;
    va_req_o    = '0;
    va_port_o   = '0;
    sa_req_o    = '0;
    sa_port_o   = '0;
    rc_head_o   = '0;
    // Lowest-index grant wins when several bits are set
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      sa_sel_s = sa_grant_i[v] ? VC_W'(v) : sa_sel_s;
    end
    sa_multi_s = |(sa_grant_i & (sa_grant_i - VC_NUM'(1'b1)));
    err_s      = sa_multi_s;
    for (int v = 0; v < VC_NUM; v++) begin
      front_s[v]   = mem_r[v][rd_ptr_r[v]];
      cnt_nxt_s[v] = cnt_r[v];
      vc_empty_s   = (cnt_r[v] == '0);
      idle_drop_s  = (state_r[v] == S_IDLE) && !vc_empty_s && !is_head(front_s[v].flit_label);
      sa_pop_s[v]  = sa_grant_i[v] && (sa_sel_s == VC_W'(v)) &&
                     (state_r[v] == S_ACTIVE) && !vc_empty_s;
      pop_s[v]     = idle_drop_s || sa_pop_s[v];
      wr_hit_s     = valid_flit_i && (wr_vc_s == VC_W'(v));
      // A full VC still accepts a push when it pops in the same cycle
      push_s[v]    = wr_hit_s && ((cnt_r[v] != FULL_CNT) || pop_s[v]);
      cnt_nxt_s[v] = cnt_r[v] + CNT_W'(push_s[v]) - CNT_W'(pop_s[v]);
      err_s = err_s | idle_drop_s | (wr_hit_s && !push_s[v]) |
              (sa_grant_i[v] && ((state_r[v] != S_ACTIVE) || vc_empty_s)) |
              (va_grant_i[v] && (state_r[v] != S_VA));
      rc_head_o[v] = front_s[v];
      va_req_o[v]  = (state_r[v] == S_VA);
      va_port_o[v] = out_port_r[v];
      sa_req_o[v]  = (state_r[v] == S_ACTIVE) && !vc_empty_s;
      sa_port_o[v] = out_port_r[v];
    end
    pop_flit_s                  = front_s[sa_sel_s];
    pop_flit_s.vc_id            = '0;
    pop_flit_s.vc_id[VC_W-1:0]  = down_vc_r[sa_sel_s];
    pop_port_s                  = out_port_r[sa_sel_s];
  end

  // Flit storage; contents need no reset since counts gate every read
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (push_s[v]) mem_r[v][wr_ptr_r[v]] <= data_i;
    end
  end

  // Buffer pointers, occupancy and registered full/empty views
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_r[v] <= '0;
        rd_ptr_r[v] <= '0;
        cnt_r[v]    <= '0;
      end
      is_full_r  <= '0;
      is_empty_r <= '1;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (push_s[v]) wr_ptr_r[v] <= wr_ptr_r[v] + PTR_W'(1'b1);
        if (pop_s[v])  rd_ptr_r[v] <= rd_ptr_r[v] + PTR_W'(1'b1);
        cnt_r[v]      <= cnt_nxt_s[v];
        is_full_r[v]  <= (cnt_nxt_s[v] == FULL_CNT);
        is_empty_r[v] <= (cnt_nxt_s[v] == '0);
      end
    end
  end

  // Per-VC pipeline FSM; an idle VC receiving a head into an empty buffer enters RC directly
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_r[v]    <= S_IDLE;
        out_port_r[v] <= '0;
        down_vc_r[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        case (state_r[v])
          S_IDLE: begin
            if (cnt_r[v] != '0) begin
              if (is_head(front_s[v].flit_label)) state_r[v] <= S_RC;
            end else if (push_s[v] && is_head(data_i.flit_label)) begin
              state_r[v] <= S_RC;
            end
          end
          S_RC: begin
            out_port_r[v] <= rc_port_i[v];
            state_r[v]    <= S_VA;
          end
          S_VA: begin
            if (va_grant_i[v]) begin
              down_vc_r[v] <= va_vc_i[v];
              state_r[v]   <= S_ACTIVE;
            end
          end
          S_ACTIVE: begin
            if (sa_pop_s[v] && is_last(front_s[v].flit_label)) state_r[v] <= S_IDLE;
          end
          default: state_r[v] <= S_IDLE;
        endcase
      end
    end
  end

  // Crossbar output register and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      xb_flit_r  <= '0;
      xb_valid_r <= 1'b0;
      xb_port_r  <= '0;
      error_r    <= 1'b0;
    end else begin
      xb_valid_r <= |sa_pop_s;
      if (|sa_pop_s) begin
        xb_flit_r <= pop_flit_s;
        xb_port_r <= pop_port_s;
      end
      error_r <= error_r | err_s;
    end
  end

  assign is_full_o  = is_full_r;
  assign is_empty_o = is_empty_r;
  assign xb_flit_o  = xb_flit_r;
  assign xb_valid_o = xb_valid_r;
  assign xb_port_o  = xb_port_r;
  assign error_o    = error_r;

endmodule

// File: doc/input_port_vc.md
Name: input_port_vc

Overview:
- Next-generation router input port: parametrised number of virtual channels (VCs), one circular flit buffer per VC, and a per-VC pipeline control FSM.
- The FSM sequences route computation (RC), VC allocation (VA) and switch allocation (SA).
- Sits between the upstream link and the router allocators/crossbar. Presents one registered flit per cycle to the crossbar.

Parameters:
- VC_NUM, 2, number of virtual channels (>=1, power of two).
- BUFFER_SIZE, 8, flit capacity of each VC buffer (>=2, power of two).
- PORT_NUM, 5, router output ports; PORT_W = $clog2(PORT_NUM), VC_W = max(1,$clog2(VC_NUM)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- data_i  in  flit_t  incoming flit; data_i.vc_id selects the VC; flit_label in {HEAD, BODY, TAIL, HEADTAIL}
- valid_flit_i  in  1  data_i valid this cycle
- is_full_o  out  VC_NUM  per-VC buffer full (credit back-pressure)
- is_empty_o  out  VC_NUM  per-VC buffer empty
- rc_head_o  out  VC_NUM x flit_t  front flit of each VC, fed to the combinational RC unit
- rc_port_i  in  VC_NUM x PORT_W  RC result per VC, valid same cycle
- va_req_o  out  VC_NUM  VA request
- va_port_o  out  VC_NUM x PORT_W  requested output port
- va_grant_i  in  VC_NUM  VA grant
- va_vc_i  in  VC_NUM x VC_W  downstream VC granted
- sa_req_o  out  VC_NUM  SA request
- sa_port_o  out  VC_NUM x PORT_W  SA target port
- sa_grant_i  in  VC_NUM  SA grant, at most one-hot
- xb_flit_o  out  flit_t  flit to crossbar, vc_id rewritten to the downstream VC
- xb_valid_o  out  1  xb_flit_o valid
- xb_port_o  out  PORT_W  destination port of xb_flit_o
- error_o  out  1  sticky protocol-violation flag

Behaviour:
Reset (rst==0 at posedge):
- All buffer pointers and counts are 0; all FSMs go to IDLE; out_port/down_vc registers are 0.
- Outputs: is_empty_o all 1, is_full_o 0, va_req_o 0, sa_req_o 0, xb_valid_o 0, xb_flit_o 0, xb_port_o 0, error_o 0.
- Reset mid-packet discards all buffered flits.

Buffer write (BW):
- When valid_flit_i=1, data_i is pushed into VC data_i.vc_id at the next edge.
- Push to a full VC: flit dropped, error_o<=1.
- Simultaneous push and pop on a full VC: both are accepted; the count stays BUFFER_SIZE.
- Pointers wrap modulo BUFFER_SIZE.
- is_full_o and is_empty_o are registered views of the count.

Per-VC FSM (IDLE, RC, VA, ACTIVE):
- IDLE:
  - Buffer non-empty and front label HEAD/HEADTAIL -> RC.
  - Front label BODY/TAIL -> error_o<=1, the flit is dropped, stay in IDLE.
- RC: out_port <= rc_port_i[v] in exactly one cycle -> VA.
- VA:
  - va_req_o[v]=1 and va_port_o[v]=out_port.
  - On va_grant_i[v]: down_vc <= va_vc_i[v] -> ACTIVE.
  - No timeout; the request holds until granted.
- ACTIVE:
  - sa_req_o[v] = buffer non-empty; sa_port_o[v]=out_port.
  - On sa_grant_i[v], pop the front flit. Next cycle: xb_valid_o=1, xb_flit_o=the flit with vc_id=down_vc, xb_port_o=out_port.
  - If the popped label is TAIL/HEADTAIL -> IDLE, else stay in ACTIVE.

Latency and timing:
- HEAD written at cycle t: RC at t+1, VA request from t+2. If granted at t+2, sa_req_o at t+3; with a grant at t+3, the flit is on the crossbar at t+4.
- A flit arriving in the same cycle its VC empties is not bypassed; it waits at least one cycle in the buffer.
- A packet's next HEAD, queued behind a TAIL, is entered via IDLE on the cycle after the TAIL pops.

Grant violations (each sets error_o<=1):
- sa_grant_i bit set for a VC not in ACTIVE or with an empty buffer: ignored.
- Multiple sa_grant_i bits set: only the lowest index is served.
- va_grant_i outside VA: ignored.

Behaviour common to all states:
- xb_valid_o is 0 in any cycle following no pop.
- error_o clears only on reset.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1 -> is_empty_o=2'b11, xb_valid_o=0, error_o=0 throughout.
- HEADTAIL packet: HEADTAIL flit on VC0, rc_port_i[0]=3, va_grant with va_vc_i=1, immediate sa_grant -> xb_valid_o=1 at t+4, xb_port_o=3, xb_flit_o.vc_id=1, VC0 back to IDLE, is_empty_o[0]=1.
- 4-flit packet H,B,B,T on VC1 with SA grant every other cycle -> four xb flits in order, 2 cycles apart, then VC1 IDLE.
- Fill VC0 with 8 flits without SA grants -> is_full_o[0]=1; 9th push dropped, error_o=1. Simultaneous push and pop at full -> count stays 8, no error.
- Interleaved VCs: packets on VC0 and VC1; sa_grant alternating 01/10 -> flits are not mixed within a VC, and each carries its own down_vc and out_port.
- Violations: BODY as first flit on an idle VC, sa_grant_i=2'b11 -> error_o=1, only VC0 served, dropped BODY never appears on xb_flit_o.
